mem_stage_unit: RTL and testbench

- Consumer of the EX/MEM pipeline register outputs (PCSrcM, RegWriteM, MemtoRegM, MemWriteM, RdM, ALUResultM, WriteDataM).
- Drives the data-memory request/acknowledge interface for loads and stores.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the completed instruction into the MEM/WB stage (W-stage outputs).

---
 rtl/mem_stage_unit.sv | 143 ++++++++++++++
 tb/tb_mem_stage_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM pipeline stage. Issues data-memory loads/stores from the
// EX/MEM register, stalls upstream while an access is outstanding, and
// registers the completed instruction into the MEM/WB (W) outputs.
// Optional build macro: MEM_TIMEOUT_EN enables a BUSY watchdog that aborts
// an access after TIMEOUT_CYCLES cycles without ack and sets sticky MemErr.
module mem_stage_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [3:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [3:0]  RdW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic        MemErr
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      r_state;
  logic [31:0] r_buf;
  logic        w_acc;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wdog;
  logic       r_to;
  logic       r_err;
  assign MemErr = r_err;
`else
  assign MemErr = 1'b0;
`endif

  assign w_acc = MemtoRegM | MemWriteM;

  // Hold upstream while an access is being launched or is outstanding
  assign StallM = (r_state == S_BUSY) | ((r_state == S_IDLE) & w_acc);

  // Stage FSM: memory request handshake and W-stage register updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      PCSrcW     <= 1'b0;
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      RdW        <= '0;
      ALUOutW    <= '0;
      ReadDataW  <= '0;
`ifdef MEM_TIMEOUT_EN
      r_wdog     <= '0;
      r_to       <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= ALUResultM;
            dmem_wdata <= WriteDataM;
            PCSrcW     <= 1'b0;
            RegWriteW  <= 1'b0;
            MemtoRegW  <= 1'b0;
            r_state    <= S_BUSY;
`ifdef MEM_TIMEOUT_EN
            r_wdog     <= '0;
            r_to       <= 1'b0;
`endif
          end else begin
            PCSrcW    <= PCSrcM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            RdW       <= RdM;
            ALUOutW   <= ALUResultM;
          end
        end
        S_BUSY: begin
          PCSrcW    <= 1'b0;
          RegWriteW <= 1'b0;
          MemtoRegW <= 1'b0;
          if (dmem_ack) begin
            if (!dmem_we) r_buf <= dmem_rdata;
            dmem_req <= 1'b0;
            r_state  <= S_DONE;
`ifdef MEM_TIMEOUT_EN
          end else if (r_wdog == LP_WD_LAST) begin
            // ack on the timeout edge takes the branch above, so no error then
            dmem_req <= 1'b0;
            r_err    <= 1'b1;
            r_to     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
`endif
          end
        end
        S_DONE: begin
          PCSrcW    <= PCSrcM;
          RegWriteW <= RegWriteM;
          MemtoRegW <= MemtoRegM;
          RdW       <= RdM;
          ALUOutW   <= ALUResultM;
          if (MemtoRegM) ReadDataW <= r_buf;
`ifdef MEM_TIMEOUT_EN
          if (r_to) begin
            RegWriteW <= 1'b0;
            ReadDataW <= '0;
          end
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: random instruction stream against a transaction-level
// model of the MEM stage (per-instruction stall length, request contents and
// resulting W-stage values).
`timescale 1ns/1ps
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        StallM, PCSrcW, RegWriteW, MemtoRegW, MemErr;
  logic [3:0]  RdW;
  logic [31:0] ALUOutW, ReadDataW;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // model of architectural W-stage contents
  logic        m_pcs, m_rw, m_mtr, m_err;
  logic [3:0]  m_rd;
  logic [31:0] m_alu, m_rdw, m_buf;

  always #5 clk = ~clk;

  mem_stage_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .RdW(RdW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .MemErr(MemErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_w(input string tag);
    check({tag, ".pcsW"}, 32'(PCSrcW),    32'(m_pcs));
    check({tag, ".rwW"},  32'(RegWriteW), 32'(m_rw));
    check({tag, ".mtrW"}, 32'(MemtoRegW), 32'(m_mtr));
    check({tag, ".rdW"},  32'(RdW),       32'(m_rd));
    check({tag, ".aluW"}, ALUOutW,        m_alu);
    check({tag, ".rdatW"}, ReadDataW,     m_rdw);
    check({tag, ".err"},  32'(MemErr),    32'(m_err));
  endtask

  task automatic model_reset();
    m_pcs = 0; m_rw = 0; m_mtr = 0; m_rd = '0; m_alu = '0; m_rdw = '0; m_err = 0;
  endtask

  task automatic drive_m(input logic pcs, rw, mtr, mw, input logic [3:0] rd,
                         input logic [31:0] alu, wd);
    PCSrcM = pcs; RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
    RdM = rd; ALUResultM = alu; WriteDataM = wd;
  endtask

  // One instruction held in M until it leaves; called at posedge+1.
  // d = number of BUSY cycles before the ack cycle; tmo = never ack.
  task automatic run_instr(input logic pcs, rw, mtr, mw, input logic [3:0] rd,
                           input logic [31:0] alu, wd, input int unsigned d,
                           input logic [31:0] rdata, input bit tmo);
    int unsigned nbusy;
    drive_m(pcs, rw, mtr, mw, rd, alu, wd);
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    if (!(mtr | mw)) begin
      dmem_ack = ($urandom_range(0, 3) == 0);  // ack with no request: ignored
      #1;
      check("alu.stall", 32'(StallM), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      m_pcs = pcs; m_rw = rw; m_mtr = mtr; m_rd = rd; m_alu = alu;
      check_w("alu");
    end else begin
      #1;
      check("acc.stall0", 32'(StallM), 32'd1);
      check("acc.idlereq", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      m_pcs = 0; m_rw = 0; m_mtr = 0;
      nbusy = tmo ? 4 : d + 1;
      for (int unsigned k = 0; k < nbusy; k++) begin
        check("busy.stall", 32'(StallM), 32'd1);
        check("busy.req",   32'(dmem_req), 32'd1);
        check("busy.we",    32'(dmem_we), 32'(mw));
        check("busy.addr",  dmem_addr, alu);
        check("busy.wdata", dmem_wdata, wd);
        check_w("bubble");
        dmem_ack   = !tmo && (k == d);
        dmem_rdata = dmem_ack ? rdata : $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
      // DONE cycle
      check("done.req", 32'(dmem_req), 32'd0);
      check("done.stall", 32'(StallM), 32'd0);
      if (tmo) m_err = 1;
      check("done.err", 32'(MemErr), 32'(m_err));
      dmem_ack = ($urandom_range(0, 1) == 0);
      dmem_rdata = $urandom;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (!tmo && !mw) m_buf = rdata;
      m_pcs = pcs; m_rw = tmo ? 1'b0 : rw; m_mtr = mtr; m_rd = rd; m_alu = alu;
      if (tmo) m_rdw = '0;
      else if (mtr) m_rdw = m_buf;
      check_w(tmo ? "tmo" : "mem");
    end
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive_m(0, 0, 0, 0, 4'h0, '0, '0);
    m_buf = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.req", 32'(dmem_req), 32'd0);
    check("rst.we", 32'(dmem_we), 32'd0);
    check("rst.addr", dmem_addr, 32'd0);
    check("rst.wdata", dmem_wdata, 32'd0);
    check_w("rst");

    // directed: ALU op, load, delayed store, back-to-back load/store
    run_instr(0, 1, 0, 0, 4'h3, 32'h0000_0010, 32'h0, 0, 32'h0, 0);
    run_instr(0, 1, 1, 0, 4'h5, 32'h0000_0100, 32'h0, 0, 32'hCAFE_F00D, 0);
    run_instr(0, 0, 0, 1, 4'h6, 32'h0000_0200, 32'h1234_5678, 3, 32'h0, 0);
    run_instr(0, 1, 1, 0, 4'h7, 32'h0000_0300, 32'h0, 1, 32'hA5A5_0001, 0);
    run_instr(0, 0, 0, 1, 4'h8, 32'h0000_0304, 32'h5A5A_0002, 0, 32'h0, 0);

    // reset in the 2nd BUSY cycle with a simultaneous ack
    drive_m(1, 1, 1, 0, 4'h9, 32'h0000_0400, 32'h0);
    @(posedge clk); #1;
    check("rb.req1", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b0; dmem_ack = 1'b0;
    model_reset();
    check("rb.req", 32'(dmem_req), 32'd0);
    check_w("rb");
    drive_m(0, 0, 0, 0, 4'h0, '0, '0);
    #1;
    check("rb.stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    check_w("rb.nop");

    // random stream
    for (int i = 0; i < 150; i++) begin
      logic [2:0] kind;
      logic mtr, mw;
      kind = 3'($urandom_range(0, 5));
      mtr = (kind == 1) || (kind == 2);
      mw  = (kind == 3) || (kind == 4);
      run_instr(1'($urandom), 1'($urandom), mtr, mw, 4'($urandom), $urandom, $urandom,
                $urandom_range(0, 3), $urandom, 0);
    end

`ifdef MEM_TIMEOUT_EN
    // watchdog abort, sticky error, then cleared only by reset
    run_instr(0, 1, 1, 0, 4'hA, 32'h0000_0500, 32'h0, 0, 32'h0, 1);
    run_instr(0, 1, 1, 0, 4'hB, 32'h0000_0504, 32'h0, 2, 32'h1111_2222, 0);
    run_instr(0, 1, 0, 0, 4'hC, 32'h0000_0042, 32'h0, 0, 32'h0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_w("tmo.rst");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
